// File: rtl/cpu_trace_buffer.sv
// Passive retirement-trace FIFO for the multi-cycle CPU, with an arm/trigger/freeze capture FSM.
// Define CPU_TRACE_TS_EN to prepend a free-running TS_W-bit cycle timestamp to every record.
module cpu_trace_buffer #(
    parameter int DEPTH        = 16,
    parameter int STOP_ON_FULL = 1,
    parameter int TS_W         = 16,
`ifdef CPU_TRACE_TS_EN
    localparam int REC_W       = 40 + TS_W,
`else
    localparam int REC_W       = 40,
`endif
    localparam int CNT_W       = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             arm,
    input  logic             clear,
    input  logic             trig_en,
    input  logic [31:0]      trig_pc,
    input  logic [31:0]      cpu_pc,
    input  logic [5:0]       cpu_decode,
    input  logic             cpu_pcwre,
    input  logic             cpu_regwre,
    input  logic             cpu_zero,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [REC_W-1:0] rd_data,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    output logic [1:0]       state
);

    localparam int PTR_W = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("cpu_trace_buffer: DEPTH must be a power of two >= 2");
    end
    if (TS_W < 1) begin : g_bad_ts_w
        $error("cpu_trace_buffer: TS_W must be >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_ARMED   = 2'b01,
        S_CAPTURE = 2'b10,
        S_FROZEN  = 2'b11
    } state_t;

    state_t           r_state;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;
    logic [REC_W-1:0] r_mem [DEPTH];

    logic             w_trig;
    logic             w_push_req;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic             w_freeze;
    logic [CNT_W-1:0] w_count_nxt;
    logic [REC_W-1:0] w_rec;

`ifdef CPU_TRACE_TS_EN
    logic [TS_W-1:0]  r_ts;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_ts <= '0;
        else        r_ts <= r_ts + 1'b1;
    end

    assign w_rec = {r_ts, cpu_decode, cpu_pc, cpu_regwre, cpu_zero};
`else
    assign w_rec = {cpu_decode, cpu_pc, cpu_regwre, cpu_zero};
`endif

    // The triggering retirement itself is captured, so ARMED+trigger counts as capturing.
    assign w_trig     = cpu_pcwre && (!trig_en || cpu_pc == trig_pc);
    assign w_push_req = !clear && cpu_pcwre &&
                        (r_state == S_CAPTURE || (r_state == S_ARMED && w_trig));
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == CNT_W'(DEPTH));
    assign w_pop      = !clear && !w_empty && rd_ready;
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_drop     = !clear && ((w_push_req && !w_push) ||
                                   (r_state == S_FROZEN && cpu_pcwre));

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop)      w_count_nxt = r_count + 1'b1;
        else if (w_pop && !w_push) w_count_nxt = r_count - 1'b1;
    end

    assign w_freeze = (STOP_ON_FULL != 0) && w_push_req && (w_count_nxt == CNT_W'(DEPTH));

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_rec;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (clear) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_nxt;
            if (w_drop) r_overflow <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (arm) r_state <= S_ARMED;
                end
                S_ARMED: begin
                    if (w_trig) r_state <= w_freeze ? S_FROZEN : S_CAPTURE;
                end
                S_CAPTURE: begin
                    if (arm)           r_state <= S_ARMED;
                    else if (w_freeze) r_state <= S_FROZEN;
                end
                S_FROZEN: begin
                    if (arm) r_state <= S_ARMED;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rd_valid = !w_empty;
    assign rd_data  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign count    = r_count;
    assign overflow = r_overflow;
    assign state    = r_state;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Bench for cpu_trace_buffer: a freezing (STOP_ON_FULL=1) and a free-running (STOP_ON_FULL=0)
// instance share stimulus and are compared each cycle against a queue-style reference model.
module tb_cpu_trace_buffer;

    localparam int D    = 16;
    localparam int TS_W = 16;
`ifdef CPU_TRACE_TS_EN
    localparam int REC_W = 40 + TS_W;
`else
    localparam int REC_W = 40;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        arm, clear, trig_en;
    logic [31:0] trig_pc, cpu_pc;
    logic [5:0]  cpu_decode;
    logic        cpu_pcwre, cpu_regwre, cpu_zero;
    logic        rd_ready;

    logic             rd_valid_o [2];
    logic [REC_W-1:0] rd_data_o  [2];
    logic [4:0]       count_o    [2];
    logic             overflow_o [2];
    logic [1:0]       state_o    [2];

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    cpu_trace_buffer #(.DEPTH(D), .STOP_ON_FULL(1), .TS_W(TS_W)) u_stop (
        .clk(clk), .reset(reset), .arm(arm), .clear(clear), .trig_en(trig_en),
        .trig_pc(trig_pc), .cpu_pc(cpu_pc), .cpu_decode(cpu_decode), .cpu_pcwre(cpu_pcwre),
        .cpu_regwre(cpu_regwre), .cpu_zero(cpu_zero), .rd_valid(rd_valid_o[0]),
        .rd_ready(rd_ready), .rd_data(rd_data_o[0]), .count(count_o[0]),
        .overflow(overflow_o[0]), .state(state_o[0])
    );

    cpu_trace_buffer #(.DEPTH(D), .STOP_ON_FULL(0), .TS_W(TS_W)) u_run (
        .clk(clk), .reset(reset), .arm(arm), .clear(clear), .trig_en(trig_en),
        .trig_pc(trig_pc), .cpu_pc(cpu_pc), .cpu_decode(cpu_decode), .cpu_pcwre(cpu_pcwre),
        .cpu_regwre(cpu_regwre), .cpu_zero(cpu_zero), .rd_valid(rd_valid_o[1]),
        .rd_ready(rd_ready), .rd_data(rd_data_o[1]), .count(count_o[1]),
        .overflow(overflow_o[1]), .state(state_o[1])
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: state as 0..3, FIFO as a shift array (slot 0 is the oldest record).
    int               m_st  [2];
    bit               m_ovf [2];
    int               m_n   [2];
    logic [REC_W-1:0] m_buf [2][D];
`ifdef CPU_TRACE_TS_EN
    logic [TS_W-1:0]  m_ts;
`endif

    task automatic model_step(input int k);
        logic [REC_W-1:0] rec;
        bit stop, trig, want, full_now;
        stop = (k == 0);
`ifdef CPU_TRACE_TS_EN
        rec = {m_ts, cpu_decode, cpu_pc, cpu_regwre, cpu_zero};
`else
        rec = {cpu_decode, cpu_pc, cpu_regwre, cpu_zero};
`endif
        if (clear) begin
            m_st[k] = 0; m_n[k] = 0; m_ovf[k] = 1'b0;
        end else begin
            trig = cpu_pcwre && (!trig_en || cpu_pc == trig_pc);
            want = cpu_pcwre && (m_st[k] == 2 || (m_st[k] == 1 && trig));
            if (m_n[k] > 0 && rd_ready) begin
                for (int j = 0; j < D - 1; j++) m_buf[k][j] = m_buf[k][j+1];
                m_n[k]--;
            end
            if (want) begin
                if (m_n[k] < D) begin
                    m_buf[k][m_n[k]] = rec;
                    m_n[k]++;
                end else begin
                    m_ovf[k] = 1'b1;
                end
            end
            if (m_st[k] == 3 && cpu_pcwre) m_ovf[k] = 1'b1;
            full_now = want && (m_n[k] == D);
            case (m_st[k])
                0: if (arm) m_st[k] = 1;
                1: if (trig) m_st[k] = (stop && full_now) ? 3 : 2;
                2: if (arm) m_st[k] = 1; else if (stop && full_now) m_st[k] = 3;
                default: if (arm) m_st[k] = 1;
            endcase
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
`ifdef CPU_TRACE_TS_EN
            m_ts = '0;
`endif
            for (int k = 0; k < 2; k++) begin
                m_st[k] = 0; m_n[k] = 0; m_ovf[k] = 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) model_step(k);
`ifdef CPU_TRACE_TS_EN
            m_ts = m_ts + 1'b1;
`endif
        end
    end

    always @(negedge clk) begin
        if (cmp_en && reset) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("u%0d.state", k),    64'(state_o[k]),    64'(m_st[k]));
                check($sformatf("u%0d.count", k),    64'(count_o[k]),    64'(m_n[k]));
                check($sformatf("u%0d.rd_valid", k), 64'(rd_valid_o[k]), 64'(m_n[k] > 0));
                check($sformatf("u%0d.overflow", k), 64'(overflow_o[k]), 64'(m_ovf[k]));
                check($sformatf("u%0d.rd_data", k),  64'(rd_data_o[k]),
                      (m_n[k] > 0) ? 64'(m_buf[k][0]) : 64'd0);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic retire(input logic [31:0] pc);
        cpu_pcwre  = 1'b1;
        cpu_pc     = pc;
        cpu_decode = pc[7:2];
        cpu_regwre = pc[2];
        cpu_zero   = pc[3];
        @(negedge clk);
        cpu_pcwre  = 1'b0;
    endtask

    task automatic pulse_arm();
        arm = 1'b1; @(negedge clk); arm = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1; @(negedge clk); clear = 1'b0;
    endtask

    logic [REC_W-1:0] ra, rb;

    initial begin
        reset = 1'b0; arm = 1'b0; clear = 1'b0; trig_en = 1'b0; trig_pc = '0;
        cpu_pc = '0; cpu_decode = '0; cpu_pcwre = 1'b0; cpu_regwre = 1'b0; cpu_zero = 1'b0;
        rd_ready = 1'b0;
        idle(2);
        reset = 1'b1;
        cmp_en = 1'b1;
        idle(1);
        check("reset_state", 64'(state_o[0]), 64'd0);
        check("reset_count", 64'(count_o[0]), 64'd0);

        // Untriggered capture of three retirements, then in-order readout.
        pulse_arm();
        retire(32'h0); retire(32'h4); retire(32'h8);
        idle(1);
        check("t2_count", 64'(count_o[0]), 64'd3);
        check("t2_model_count", 64'(m_n[0]), 64'd3);
        check("t2_state", 64'(state_o[1]), 64'd2);
        rd_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("t2_read_pc", 64'(rd_data_o[0][33:2]), 64'(i * 4));
            @(negedge clk);
        end
        rd_ready = 1'b0;
        check("t2_drained", 64'(count_o[0]), 64'd0);

        // Asynchronous reset between edges takes effect before the next edge.
        retire(32'h40);
        idle(1);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check("t1_state", 64'(state_o[k]), 64'd0);
            check("t1_count", 64'(count_o[k]), 64'd0);
            check("t1_valid", 64'(rd_valid_o[k]), 64'd0);
            check("t1_ovf", 64'(overflow_o[k]), 64'd0);
            check("t1_data", 64'(rd_data_o[k]), 64'd0);
        end
        @(negedge clk);
        reset = 1'b1;

        // Two retirements four cycles apart, then clear.
        pulse_arm();
        retire(32'h80);
        idle(3);
        retire(32'h90);
        idle(1);
        ra = rd_data_o[0];
        check("t6_pc_a", 64'(ra[33:2]), 64'h80);
        rd_ready = 1'b1; @(negedge clk); rd_ready = 1'b0;
        rb = rd_data_o[0];
        check("t6_pc_b", 64'(rb[33:2]), 64'h90);
`ifdef CPU_TRACE_TS_EN
        check("t6_ts_delta", 64'(TS_W'(rb[REC_W-1 -: TS_W] - ra[REC_W-1 -: TS_W])), 64'd4);
`endif
        pulse_clear();
        check("t6_clear_count", 64'(count_o[0]), 64'd0);
        check("t6_clear_state", 64'(state_o[0]), 64'd0);

        // PC-matched trigger.
        trig_en = 1'b1; trig_pc = 32'h10;
        pulse_arm();
        for (int i = 0; i < 8; i++) retire(32'(i * 4));
        idle(1);
        check("t3_count", 64'(count_o[0]), 64'd4);
        check("t3_first_pc", 64'(rd_data_o[0][33:2]), 64'h10);
        pulse_clear();
        trig_en = 1'b0;

        // Twenty retirements, no readout: freeze vs. keep-running with drops.
        pulse_arm();
        for (int i = 0; i < 20; i++) retire(32'(i * 4));
        idle(1);
        check("t4_stop_count", 64'(count_o[0]), 64'd16);
        check("t4_stop_state", 64'(state_o[0]), 64'd3);
        check("t4_stop_ovf", 64'(overflow_o[0]), 64'd1);
        check("t4_run_state", 64'(state_o[1]), 64'd2);
        check("t4_run_ovf", 64'(overflow_o[1]), 64'd1);
        rd_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("t4_stop_pc", 64'(rd_data_o[0][33:2]), 64'(i * 4));
            check("t4_run_pc", 64'(rd_data_o[1][33:2]), 64'(i * 4));
            @(negedge clk);
        end
        rd_ready = 1'b0;
        check("t4_empty", 64'(rd_valid_o[0]), 64'd0);

        // Full FIFO with concurrent push and pop every cycle.
        pulse_clear();
        pulse_arm();
        for (int i = 0; i < 16; i++) retire(32'h200 + 32'(i * 4));
        check("t5_fill_stop_state", 64'(state_o[0]), 64'd3);
        check("t5_fill_run_count", 64'(count_o[1]), 64'd16);
        check("t5_fill_stop_ovf", 64'(overflow_o[0]), 64'd0);
        rd_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            retire(32'h300 + 32'(i * 4));
            check("t5_run_count", 64'(count_o[1]), 64'd16);
            check("t5_run_ovf", 64'(overflow_o[1]), 64'd0);
        end
        rd_ready = 1'b0;
        check("t5_run_front_pc", 64'(rd_data_o[1][33:2]), 64'h228);
        check("t5_stop_count", 64'(count_o[0]), 64'd6);
        check("t5_stop_ovf", 64'(overflow_o[0]), 64'd1);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
